// File: rtl/tim6_cnt_core_if.sv
// Control/status bundle between the TIM6 register block and its counting core.
// master = register side (drives controls), slave = counting core.
interface tim6_cnt_core_if #(
  parameter int CNT_W = 16
) ();
  logic             cen;
  logic             udis;
  logic             urs;
  logic             opm;
  logic             arpe;
  logic [CNT_W-1:0] psc_in;
  logic [CNT_W-1:0] arr_in;
  logic             ug;
  logic [CNT_W-1:0] cnt;
  logic             uif_set;
  logic             cen_clr;
  logic             trgo;

  modport master (
    output cen, udis, urs, opm, arpe, psc_in, arr_in, ug,
    input  cnt, uif_set, cen_clr, trgo
  );

  modport slave (
    input  cen, udis, urs, opm, arpe, psc_in, arr_in, ug,
    output cnt, uif_set, cen_clr, trgo
  );
endinterface

// File: rtl/tim6_cnt_core.sv
// TIM6 counting core: prescaler, up-counter, ARR/PSC shadows and update-event pulses.
// Optional TIM6_DBG_FREEZE_EN adds a dbg_halt input that freezes counting.
module tim6_cnt_core #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef TIM6_DBG_FREEZE_EN
  input  logic             dbg_halt,
`endif
  tim6_cnt_core_if.slave   bus
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] psc_cnt_q, psc_cnt_d;
  logic [CNT_W-1:0] psc_act_q, psc_act_d;
  logic [CNT_W-1:0] arr_act_q, arr_act_d;
  logic             ug_q;
  logic             opm_halt_q, opm_halt_d;
  logic             uif_set_q, uif_set_d;
  logic             cen_clr_q, cen_clr_d;
  logic             trgo_q, trgo_d;

  logic freeze;
  logic ug_pulse;
  logic run;
  logic tick;
  logic ovf;
  logic uev;

`ifdef TIM6_DBG_FREEZE_EN
  assign freeze = dbg_halt;
`else
  assign freeze = 1'b0;
`endif

  assign ug_pulse = bus.ug & ~ug_q;
  assign run      = bus.cen & ~opm_halt_q & ~freeze;
  assign tick     = run & (psc_cnt_q == psc_act_q);
  // A zero auto-reload parks the counter at 0 and never produces an overflow.
  assign ovf      = tick & (arr_act_q != '0) & (cnt_q == arr_act_q);
  assign uev      = (ug_pulse | ovf) & ~bus.udis;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no latch is inferred.
    cnt_d      = cnt_q;
    psc_cnt_d  = psc_cnt_q;
    psc_act_d  = psc_act_q;
    arr_act_d  = bus.arpe ? arr_act_q : bus.arr_in;
    opm_halt_d = opm_halt_q & bus.cen;
    uif_set_d  = 1'b0;
    cen_clr_d  = 1'b0;
    trgo_d     = 1'b0;

    if (run) begin
      psc_cnt_d = tick ? '0 : psc_cnt_q + 1'b1;
    end

    if (tick) begin
      if ((arr_act_q == '0) || ovf) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (uev) begin
      psc_act_d = bus.psc_in;
      arr_act_d = bus.arr_in;
      trgo_d    = 1'b1;
    end

    // UG takes priority over a coincident overflow so only one UEV is seen.
    if (ug_pulse) begin
      cnt_d     = '0;
      psc_cnt_d = '0;
      uif_set_d = ~bus.udis & ~bus.urs;
    end else if (ovf && !bus.udis) begin
      uif_set_d = 1'b1;
      if (bus.opm) begin
        cen_clr_d  = 1'b1;
        opm_halt_d = 1'b1;
      end
    end
  end

  // NOTE: clocked state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      psc_cnt_q  <= '0;
      psc_act_q  <= '0;
      arr_act_q  <= '0;
      ug_q       <= 1'b0;
      opm_halt_q <= 1'b0;
      uif_set_q  <= 1'b0;
      cen_clr_q  <= 1'b0;
      trgo_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      psc_cnt_q  <= psc_cnt_d;
      psc_act_q  <= psc_act_d;
      arr_act_q  <= arr_act_d;
      ug_q       <= bus.ug;
      opm_halt_q <= opm_halt_d;
      uif_set_q  <= uif_set_d;
      cen_clr_q  <= cen_clr_d;
      trgo_q     <= trgo_d;
    end
  end

  assign bus.cnt     = cnt_q;
  assign bus.uif_set = uif_set_q;
  assign bus.cen_clr = cen_clr_q;
  assign bus.trgo    = trgo_q;

endmodule

// File: tb/tb_tim6_cnt_core.sv
// Scoreboard bench for tim6_cnt_core: expected samples are queued with the stimulus
// and compared against a per-cycle monitor of cnt/uif_set/cen_clr/trgo.
module tb_tim6_cnt_core;
  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         uif;
    logic         clr;
    logic         trgo;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef TIM6_DBG_FREEZE_EN
  logic dbg_halt = 1'b0;
`endif

  tim6_cnt_core_if #(.CNT_W(W)) bus ();

  tim6_cnt_core #(.CNT_W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef TIM6_DBG_FREEZE_EN
    .dbg_halt (dbg_halt),
`endif
    .bus      (bus)
  );

  always #5 clk = ~clk;

  obs_t exp_q[$];
  obs_t obs_q[$];
  bit   mon_en = 1'b0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  always @(posedge clk) begin
    obs_t o;
    #1;
    if (mon_en) begin
      o.cnt  = bus.cnt;
      o.uif  = bus.uif_set;
      o.clr  = bus.cen_clr;
      o.trgo = bus.trgo;
      obs_q.push_back(o);
    end
  end

  function automatic void push_exp(int c, bit u, bit k, bit t);
    obs_t e;
    e.cnt  = c[W-1:0];
    e.uif  = u;
    e.clr  = k;
    e.trgo = t;
    exp_q.push_back(e);
  endfunction

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive_idle();
    bus.cen    = 1'b0;
    bus.udis   = 1'b0;
    bus.urs    = 1'b0;
    bus.opm    = 1'b0;
    bus.arpe   = 1'b0;
    bus.psc_in = '0;
    bus.arr_in = '0;
    bus.ug     = 1'b0;
  endtask

  task automatic apply_reset();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    drive_idle();
    exp_q.delete();
    obs_q.delete();
    cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t o;
    rst_n = 1'b0;
    drive_idle();
    #3;
    o = {bus.cnt, bus.uif_set, bus.cen_clr, bus.trgo};
    n_cmp++;
    if (o !== '0) begin
      n_bad++;
      $display("FAIL reset_held act=%h req=0", o);
    end
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    o = {bus.cnt, bus.uif_set, bus.cen_clr, bus.trgo};
    n_cmp++;
    if (o !== '0) begin
      n_bad++;
      $display("FAIL reset_release act=%h req=0", o);
    end
  endtask

  task automatic test_basic();
    obs_t e, o;
    apply_reset();
    bus.arr_in = 16'd4;
    cyc(1);
    bus.cen = 1'b1;
    for (int k = 1; k <= 15; k++) push_exp(k % 5, (k % 5) == 0, 1'b0, (k % 5) == 0);
    mon_en = 1'b1;
    cyc(15);
    mon_en = 1'b0;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL basic_count act=%0d req=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL basic[%0d] act cnt=%0d uif=%b clr=%b trgo=%b req cnt=%0d uif=%b clr=%b trgo=%b",
                 i, o.cnt, o.uif, o.clr, o.trgo, e.cnt, e.uif, e.clr, e.trgo);
      end
    end
  endtask

  task automatic test_prescaler();
    obs_t e, o;
    apply_reset();
    bus.psc_in = 16'd2;
    bus.arr_in = 16'd3;
    bus.ug     = 1'b1;
    push_exp(0, 1'b1, 1'b0, 1'b1);
    mon_en = 1'b1;
    cyc(1);
    bus.ug  = 1'b0;
    bus.cen = 1'b1;
    for (int j = 1; j <= 24; j++) push_exp((j / 3) % 4, (j % 12) == 0, 1'b0, (j % 12) == 0);
    cyc(24);
    mon_en = 1'b0;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL psc_count act=%0d req=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL psc[%0d] act cnt=%0d uif=%b clr=%b trgo=%b req cnt=%0d uif=%b clr=%b trgo=%b",
                 i, o.cnt, o.uif, o.clr, o.trgo, e.cnt, e.uif, e.clr, e.trgo);
      end
    end
  endtask

  task automatic test_arpe(bit arpe);
    obs_t e, o;
    int   seq_on[];
    apply_reset();
    bus.arpe   = arpe;
    bus.arr_in = 16'd9;
    if (arpe) begin
      bus.ug = 1'b1;
      push_exp(0, 1'b1, 1'b0, 1'b1);
      mon_en = 1'b1;
      cyc(1);
      bus.ug = 1'b0;
    end else begin
      cyc(1);
    end
    bus.cen = 1'b1;
    for (int k = 1; k <= 5; k++) push_exp(k, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    cyc(5);
    bus.arr_in = 16'd3;
    if (arpe) seq_on = '{6, 7, 8, 9, 0, 1, 2, 3, 0, 1};
    else      seq_on = '{6, 7, 8, 9, 10, 11};
    foreach (seq_on[k]) push_exp(seq_on[k], seq_on[k] == 0, 1'b0, seq_on[k] == 0);
    cyc(seq_on.size());
    mon_en = 1'b0;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL arpe%0d_count act=%0d req=%0d", arpe, obs_q.size(), exp_q.size());
    end
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL arpe%0d[%0d] act cnt=%0d uif=%b clr=%b trgo=%b req cnt=%0d uif=%b clr=%b trgo=%b",
                 arpe, i, o.cnt, o.uif, o.clr, o.trgo, e.cnt, e.uif, e.clr, e.trgo);
      end
    end
  endtask

  task automatic test_ug_hold(input string name, input bit urs, input bit udis);
    obs_t e, o;
    apply_reset();
    bus.arr_in = 16'd20;
    bus.urs    = urs;
    bus.udis   = udis;
    cyc(1);
    bus.cen = 1'b1;
    for (int k = 1; k <= 7; k++) push_exp(k, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    cyc(7);
    bus.ug = 1'b1;
    push_exp(0, !urs && !udis, 1'b0, !udis);
    for (int k = 1; k <= 9; k++) push_exp(k, 1'b0, 1'b0, 1'b0);
    cyc(10);
    bus.ug = 1'b0;
    push_exp(10, 1'b0, 1'b0, 1'b0);
    push_exp(11, 1'b0, 1'b0, 1'b0);
    cyc(2);
    mon_en = 1'b0;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL %s_count act=%0d req=%0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s[%0d] act cnt=%0d uif=%b clr=%b trgo=%b req cnt=%0d uif=%b clr=%b trgo=%b",
                 name, i, o.cnt, o.uif, o.clr, o.trgo, e.cnt, e.uif, e.clr, e.trgo);
      end
    end
  endtask

  task automatic test_opm();
    obs_t e, o;
    apply_reset();
    bus.opm    = 1'b1;
    bus.arr_in = 16'd2;
    cyc(1);
    bus.cen = 1'b1;
    push_exp(1, 1'b0, 1'b0, 1'b0);
    push_exp(2, 1'b0, 1'b0, 1'b0);
    push_exp(0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) push_exp(0, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    cyc(8);
    bus.cen = 1'b0;
    push_exp(0, 1'b0, 1'b0, 1'b0);
    cyc(1);
    bus.cen = 1'b1;
    push_exp(1, 1'b0, 1'b0, 1'b0);
    push_exp(2, 1'b0, 1'b0, 1'b0);
    push_exp(0, 1'b1, 1'b1, 1'b1);
    cyc(3);
    mon_en = 1'b0;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL opm_count act=%0d req=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL opm[%0d] act cnt=%0d uif=%b clr=%b trgo=%b req cnt=%0d uif=%b clr=%b trgo=%b",
                 i, o.cnt, o.uif, o.clr, o.trgo, e.cnt, e.uif, e.clr, e.trgo);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    apply_reset();
    bus.arr_in = 16'd3;
    bus.urs    = 1'b1;
    cyc(1);
    bus.cen = 1'b1;
    for (int k = 1; k <= 3; k++) push_exp(k, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    cyc(3);
    bus.ug = 1'b1;
    push_exp(0, 1'b0, 1'b0, 1'b1);
    cyc(1);
    bus.ug = 1'b0;
    for (int k = 1; k <= 3; k++) push_exp(k, 1'b0, 1'b0, 1'b0);
    push_exp(0, 1'b1, 1'b0, 1'b1);
    cyc(4);
    mon_en = 1'b0;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL ug_ovf_count act=%0d req=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL ug_ovf[%0d] act cnt=%0d uif=%b clr=%b trgo=%b req cnt=%0d uif=%b clr=%b trgo=%b",
                 i, o.cnt, o.uif, o.clr, o.trgo, e.cnt, e.uif, e.clr, e.trgo);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    apply_reset();
    bus.arr_in = 16'd3;
    cyc(1);
    bus.cen = 1'b1;
    cyc(3);
    o = {bus.cnt, bus.uif_set, bus.cen_clr, bus.trgo};
    n_cmp++;
    if (o !== {16'd3, 3'b000}) begin
      n_bad++;
      $display("FAIL rst_mid_pre act=%h req=%h", o, {16'd3, 3'b000});
    end
    rst_n = 1'b0;
    #1;
    o = {bus.cnt, bus.uif_set, bus.cen_clr, bus.trgo};
    n_cmp++;
    if (o !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_cnt act=%h req=0", o);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    bus.cen = 1'b0;
    cyc(1);
    bus.cen = 1'b1;
    cyc(4);
    o = {bus.cnt, bus.uif_set, bus.cen_clr, bus.trgo};
    n_cmp++;
    if (o !== {16'd0, 3'b101}) begin
      n_bad++;
      $display("FAIL rst_pulse_pre act=%h req=%h", o, {16'd0, 3'b101});
    end
    rst_n = 1'b0;
    #1;
    o = {bus.cnt, bus.uif_set, bus.cen_clr, bus.trgo};
    n_cmp++;
    if (o !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_pulse act=%h req=0", o);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_basic();
    test_prescaler();
    test_arpe(1'b1);
    test_arpe(1'b0);
    test_ug_hold("ug_urs1", 1'b1, 1'b0);
    test_ug_hold("ug_urs0", 1'b0, 1'b0);
    test_ug_hold("ug_udis", 1'b0, 1'b1);
    test_opm();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
